// File: rtl/approx_mult_err_profiler.sv
// approx_mult_err_profiler
//   Exhaustive error-metric engine for an approximate WIDTHxWIDTH multiplier.
//   It walks every operand pair, compares the MUT product with the exact one
//   and accumulates error count, summed/max error distance and summed relative
//   error distance (scaled by RED_SCALE, computed with a bit-serial divider).
//
//   Optional feature macro: ERR_BIAS_EN
//     defined   : bias_sum accumulates signed (approx - exact), saturating at
//                 +/-(2^(ACC_W-1)-1); reaching a limit sets sat.
//     undefined : no bias logic, bias_sum tied to 0.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     start, abort    sweep request (IDLE only) / stop sweep keeping results
//     skip_zero       operands run 1..2^W-1 instead of 0..2^W-1 (with start)
//     op_a, op_b      registered operands to the MUT
//     approx_prod     MUT product, sampled MULT_LAT cycles after op change
//     busy, done      sweep active / one-cycle completion pulse
//     err_count, err_dist_sum, max_err, red_sum, bias_sum   metrics
//     sat, red_undef  sticky: accumulator saturated / error with exact = 0
module approx_mult_err_profiler #(
  parameter int WIDTH     = 4,
  parameter int MULT_LAT  = 0,
  parameter int ACC_W     = 32,
  parameter int RED_SCALE = 10000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 skip_zero,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   approx_prod,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [ACC_W-1:0]     err_dist_sum,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [ACC_W-1:0]     red_sum,
  output logic                 sat,
  output logic                 red_undef,
  output logic [ACC_W-1:0]     bias_sum
);
  localparam int PW      = 2 * WIDTH;
  localparam int RW      = $clog2(RED_SCALE + 1);
  localparam int DIV_CYC = PW + RW;          // also the dividend/quotient width
  localparam int SW      = ((ACC_W > DIV_CYC) ? ACC_W : DIV_CYC) + 1;
  localparam int LW      = (MULT_LAT > 1) ? $clog2(MULT_LAT + 1) : 1;
  localparam int CW      = $clog2(DIV_CYC + 1);
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  // NEXT has no state of its own: it is folded into the exit of COMPARE/DIVIDE.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_COMPARE = 3'd2;
  localparam logic [2:0] S_DIVIDE  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]         state;
  logic               skipZ;
  logic [LW-1:0]      waitCnt;
  logic [CW-1:0]      divCnt;
  logic [PW-1:0]      divisor;
  logic [PW-1:0]      rem;
  logic [DIV_CYC-1:0] quo;   // dividend shifts out the top, quotient in the bottom

  logic [PW-1:0]      exact, ed;
  logic               isErr, lastPair, clrAcc, cmpEn;
  logic [WIDTH-1:0]   firstVal, nxtA, nxtB;
  logic [2:0]         advState;
  logic [DIV_CYC-1:0] dividend, quoNext;
  logic [PW:0]        remShift;
  logic [PW-1:0]      remNext;
  logic               remGe;
  logic [SW-1:0]      edSumW, redSumW;
  logic               edSat, redSat, biasSatC;

  assign busy   = (state == S_WAIT) || (state == S_COMPARE) || (state == S_DIVIDE);
  assign done   = (state == S_DONE);
  assign clrAcc = (state == S_IDLE) && start;
  assign cmpEn  = (state == S_COMPARE) && !abort;

  always_comb begin
    exact    = PW'(op_a) * PW'(op_b);
    ed       = (approx_prod >= exact) ? approx_prod - exact : exact - approx_prod;
    isErr    = (ed != '0);
    dividend = DIV_CYC'(ed) * DIV_CYC'(RED_SCALE);
    firstVal = {{(WIDTH-1){1'b0}}, skipZ};
    lastPair = (&op_a) && (&op_b);
    // op_b runs fastest; operands hold on the final pair
    nxtA = op_a;
    nxtB = op_b + WIDTH'(1);
    if (&op_b) begin
      nxtB = firstVal;
      nxtA = op_a + WIDTH'(1);
    end
    if (lastPair) begin
      nxtA = op_a;
      nxtB = op_b;
    end
    advState = lastPair ? S_DONE : ((MULT_LAT > 0) ? S_WAIT : S_COMPARE);
    // one restoring-division step; a successful subtract always fits PW bits
    remShift = {rem, quo[DIV_CYC-1]};
    remGe    = (remShift >= {1'b0, divisor});
    remNext  = remGe ? (remShift[PW-1:0] - divisor) : remShift[PW-1:0];
    quoNext  = {quo[DIV_CYC-2:0], remGe};
    // saturating adds done one bit wider than anything that can be added
    edSumW  = SW'(err_dist_sum) + SW'(ed);
    redSumW = SW'(red_sum) + SW'(quoNext);
    edSat   = (edSumW >= ACC_MAX);
    redSat  = (redSumW >= ACC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      skipZ        <= 1'b0;
      waitCnt      <= '0;
      divCnt       <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      err_count    <= '0;
      err_dist_sum <= '0;
      max_err      <= '0;
      red_sum      <= '0;
      sat          <= 1'b0;
      red_undef    <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          err_count    <= '0;
          err_dist_sum <= '0;
          max_err      <= '0;
          red_sum      <= '0;
          sat          <= 1'b0;
          red_undef    <= 1'b0;
          skipZ        <= skip_zero;
          op_a         <= {{(WIDTH-1){1'b0}}, skip_zero};
          op_b         <= {{(WIDTH-1){1'b0}}, skip_zero};
          waitCnt      <= '0;
          state        <= (MULT_LAT > 0) ? S_WAIT : S_COMPARE;
        end
        S_WAIT: begin
          if (waitCnt == LW'(MULT_LAT - 1)) state <= S_COMPARE;
          else waitCnt <= waitCnt + LW'(1);
        end
        S_COMPARE: begin
          if (isErr) begin
            err_count    <= err_count + (PW+1)'(1);
            err_dist_sum <= edSat ? ACC_MAX[ACC_W-1:0] : edSumW[ACC_W-1:0];
            if (ed > max_err) max_err <= ed;
            sat <= sat | edSat | biasSatC;
          end
          if (isErr && exact != '0) begin
            divisor <= exact;
            quo     <= dividend;
            rem     <= '0;
            divCnt  <= '0;
            state   <= S_DIVIDE;
          end else begin
            if (isErr) red_undef <= 1'b1;
            op_a    <= nxtA;
            op_b    <= nxtB;
            waitCnt <= '0;
            state   <= advState;
          end
        end
        S_DIVIDE: begin
          rem    <= remNext;
          quo    <= quoNext;
          divCnt <= divCnt + CW'(1);
          if (divCnt == CW'(DIV_CYC - 1)) begin
            red_sum <= redSat ? ACC_MAX[ACC_W-1:0] : redSumW[ACC_W-1:0];
            sat     <= sat | redSat;
            op_a    <= nxtA;
            op_b    <= nxtB;
            waitCnt <= '0;
            state   <= advState;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ERR_BIAS_EN
  localparam int BW = ((ACC_W > PW + 1) ? ACC_W : PW + 1) + 1;
  localparam logic signed [BW-1:0] BIAS_MAX = {{(BW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [BW-1:0] BIAS_MIN = -BIAS_MAX;

  logic signed [BW-1:0] biasDiff, biasW;
  logic [ACC_W-1:0]     biasReg, biasNext;

  always_comb begin
    biasDiff = BW'({1'b0, approx_prod}) - BW'({1'b0, exact});
    biasW    = {{(BW-ACC_W){biasReg[ACC_W-1]}}, biasReg} + biasDiff;
    biasSatC = isErr && ((biasW >= BIAS_MAX) || (biasW <= BIAS_MIN));
    if (biasW >= BIAS_MAX)      biasNext = BIAS_MAX[ACC_W-1:0];
    else if (biasW <= BIAS_MIN) biasNext = BIAS_MIN[ACC_W-1:0];
    else                        biasNext = biasW[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              biasReg <= '0;
    else if (clrAcc)         biasReg <= '0;
    else if (cmpEn && isErr) biasReg <= biasNext;
  end

  assign bias_sum = biasReg;
`else
  assign biasSatC = 1'b0;
  assign bias_sum = '0;
`endif

endmodule
